// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ valid/ready requesters.
// A grant is held for a whole packet or up to MAX_BURST beats, with one idle arbitration cycle between grants.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DBIT      = 8,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DBIT-1:0]     req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [DBIT-1:0]          fifo_wr_data,
   output logic                     grant_valid,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   grant_id_q, grant_id_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

   logic            found;
   logic [IW-1:0]   winner;
   logic            owner_valid;
   logic            owner_last;
   logic [DBIT-1:0] owner_data;
   logic            beat;

   // First valid requester at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned   idx;
         logic [IW-1:0] idx_w;
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = IW'(idx);
         if (!found && req_valid[idx_w]) begin
            found  = 1'b1;
            winner = idx_w;
         end
      end
   end

   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (grant_id_q == IW'(k)) begin
            owner_valid = req_valid[k];
            owner_last  = req_last[k];
            owner_data  = req_data[k*DBIT +: DBIT];
         end
      end
   end

   assign beat = (state_q == LOCKED) && owner_valid && !fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Write path is combinational off the owner's valid so a beat lands the same cycle it is offered
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      beat_cnt_d   = beat_cnt_q;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_id_d = winner;
               beat_cnt_d = '0;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            if (beat) begin
               req_ready[grant_id_q] = 1'b1;
               fifo_wr_en            = 1'b1;
               fifo_wr_data          = owner_data;
               beat_cnt_d            = beat_cnt_q + CW'(1);
               if (owner_last || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                  state_d  = IDLE;
                  rr_ptr_d = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_valid = (state_q == LOCKED);
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DBIT=8, MAX_BURST=4).
// Each step checks {wr_en, wr_data, req_ready, grant_valid, grant_id} against hand-computed values.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic        grant_valid;
   logic [1:0]  grant_id;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_wr_arbiter #(.NREQ(4), .DBIT(8), .MAX_BURST(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] E(input logic wr, input logic [7:0] d, input logic [3:0] r,
                                     input logic gv, input logic [1:0] gid);
      return {wr, d, r, gv, gid};
   endfunction

   task automatic chk(input string tag, input logic [15:0] exp);
      logic [15:0] obs;
      obs = {fifo_wr_en, fifo_wr_data, req_ready, grant_valid, grant_id};
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed {wr,data,ready,gv,gid}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_chk(input string tag, input logic [3:0] v, input logic [3:0] l,
                            input logic [31:0] d, input logic f, input logic [15:0] exp);
      req_valid = v;
      req_last  = l;
      req_data  = d;
      fifo_full = f;
      #1;
      chk(tag, exp);
   endtask

   task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic f, input logic [15:0] exp);
      @(posedge clk);
      #1;
      drive_chk(tag, v, l, d, f, exp);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive_chk(tag, 4'h0, 4'h0, 32'h0, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      #2;
      chk("reset_state", 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single requester, 3-beat packet
      cyc("t1_c0", 4'b0010, 4'b0000, 32'h0000A100, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t1_c1", 4'b0010, 4'b0000, 32'h0000A100, 1'b0, E(1, 8'hA1, 4'b0010, 1, 2'd1));
      cyc("t1_c2", 4'b0010, 4'b0000, 32'h0000A200, 1'b0, E(1, 8'hA2, 4'b0010, 1, 2'd1));
      cyc("t1_c3", 4'b0010, 4'b0010, 32'h0000A300, 1'b0, E(1, 8'hA3, 4'b0010, 1, 2'd1));
      cyc("t1_c4", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd1));

      // All four valid with 1-beat packets: order 0,1,2,3,0
      do_reset("t2_rst");
      cyc("t2_c0", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t2_c1", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(1, 8'h20, 4'b0001, 1, 2'd0));
      cyc("t2_c2", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t2_c3", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(1, 8'h21, 4'b0010, 1, 2'd1));
      cyc("t2_c4", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd1));
      cyc("t2_c5", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(1, 8'h22, 4'b0100, 1, 2'd2));
      cyc("t2_c6", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd2));
      cyc("t2_c7", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(1, 8'h23, 4'b1000, 1, 2'd3));
      cyc("t2_c8", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd3));
      cyc("t2_c9", 4'b1111, 4'b1111, 32'h23222120, 1'b0, E(1, 8'h20, 4'b0001, 1, 2'd0));
      cyc("t2_c10", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));

      // fifo_full for two cycles mid-packet (rr_ptr=1, req2 wins)
      cyc("t3_c0", 4'b0100, 4'b0000, 32'h00B00000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t3_c1", 4'b0100, 4'b0000, 32'h00B00000, 1'b0, E(1, 8'hB0, 4'b0100, 1, 2'd2));
      cyc("t3_c2", 4'b0100, 4'b0000, 32'h00B10000, 1'b1, E(0, 8'h00, 4'b0000, 1, 2'd2));
      cyc("t3_c3", 4'b0100, 4'b0000, 32'h00B10000, 1'b1, E(0, 8'h00, 4'b0000, 1, 2'd2));
      cyc("t3_c4", 4'b0100, 4'b0000, 32'h00B10000, 1'b0, E(1, 8'hB1, 4'b0100, 1, 2'd2));
      cyc("t3_c5", 4'b0100, 4'b0000, 32'h00B20000, 1'b0, E(1, 8'hB2, 4'b0100, 1, 2'd2));
      cyc("t3_c6", 4'b0100, 4'b0100, 32'h00B30000, 1'b0, E(1, 8'hB3, 4'b0100, 1, 2'd2));
      cyc("t3_c7", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd2));

      // MAX_BURST forced release splits req2's packet around req3
      do_reset("t4_rst");
      cyc("t4_c0", 4'b0100, 4'b0000, 32'h00C00000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t4_c1", 4'b1100, 4'b1000, 32'hD0C00000, 1'b0, E(1, 8'hC0, 4'b0100, 1, 2'd2));
      cyc("t4_c2", 4'b1100, 4'b1000, 32'hD0C10000, 1'b0, E(1, 8'hC1, 4'b0100, 1, 2'd2));
      cyc("t4_c3", 4'b1100, 4'b1000, 32'hD0C20000, 1'b0, E(1, 8'hC2, 4'b0100, 1, 2'd2));
      cyc("t4_c4", 4'b1100, 4'b1000, 32'hD0C30000, 1'b0, E(1, 8'hC3, 4'b0100, 1, 2'd2));
      cyc("t4_c5", 4'b1100, 4'b1000, 32'hD0C40000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd2));
      cyc("t4_c6", 4'b1100, 4'b1000, 32'hD0C40000, 1'b0, E(1, 8'hD0, 4'b1000, 1, 2'd3));
      cyc("t4_c7", 4'b0100, 4'b0000, 32'h00C40000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd3));
      cyc("t4_c8", 4'b0100, 4'b0000, 32'h00C40000, 1'b0, E(1, 8'hC4, 4'b0100, 1, 2'd2));
      cyc("t4_c9", 4'b0100, 4'b0100, 32'h00C50000, 1'b0, E(1, 8'hC5, 4'b0100, 1, 2'd2));
      cyc("t4_c10", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd2));

      // Async reset during beat 2 of req1's packet (rr_ptr=3 beforehand)
      cyc("t5_c0", 4'b0010, 4'b0000, 32'h0000E000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd2));
      cyc("t5_c1", 4'b0010, 4'b0000, 32'h0000E000, 1'b0, E(1, 8'hE0, 4'b0010, 1, 2'd1));
      cyc("t5_c2", 4'b0010, 4'b0000, 32'h0000E100, 1'b0, E(1, 8'hE1, 4'b0010, 1, 2'd1));
      rst_n = 1'b0;
      drive_chk("t5_rst_mid", 4'b0011, 4'b0001, 32'h0000E1F0, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_chk("t5_c3", 4'b0011, 4'b0001, 32'h0000E1F0, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t5_c4", 4'b0011, 4'b0001, 32'h0000E1F0, 1'b0, E(1, 8'hF0, 4'b0001, 1, 2'd0));
      cyc("t5_c5", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));

      // Owner (req1) drops valid for 3 cycles while req0 waits
      cyc("t6_c0", 4'b0011, 4'b0001, 32'h00006070, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));
      cyc("t6_c1", 4'b0011, 4'b0001, 32'h00006070, 1'b0, E(1, 8'h60, 4'b0010, 1, 2'd1));
      cyc("t6_c2", 4'b0001, 4'b0001, 32'h00006170, 1'b0, E(0, 8'h00, 4'b0000, 1, 2'd1));
      cyc("t6_c3", 4'b0001, 4'b0001, 32'h00006170, 1'b0, E(0, 8'h00, 4'b0000, 1, 2'd1));
      cyc("t6_c4", 4'b0001, 4'b0001, 32'h00006170, 1'b0, E(0, 8'h00, 4'b0000, 1, 2'd1));
      cyc("t6_c5", 4'b0011, 4'b0001, 32'h00006170, 1'b0, E(1, 8'h61, 4'b0010, 1, 2'd1));
      cyc("t6_c6", 4'b0011, 4'b0011, 32'h00006270, 1'b0, E(1, 8'h62, 4'b0010, 1, 2'd1));
      cyc("t6_c7", 4'b0001, 4'b0001, 32'h00000070, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd1));
      cyc("t6_c8", 4'b0001, 4'b0001, 32'h00000070, 1'b0, E(1, 8'h70, 4'b0001, 1, 2'd0));
      cyc("t6_c9", 4'b0000, 4'b0000, 32'h00000000, 1'b0, E(0, 8'h00, 4'b0000, 0, 2'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
